lrsc_sequencer: RTL and testbench

- Multi-cycle sequencer for RV-A LR.W/SC.W, enabled when main control decodes an atomic opcode.
- Sits beside the EX/MEM stage, between the pipeline and the data bus.
- Stalls the pipeline while an atomic access is in flight and owns the single-hart reservation register.
- Produces the LR load value or the SC status word for register writeback.

---
 rtl/arvi_amo_pkg.sv | 19 +
 rtl/lrsc_reservation.sv | 58 +++++
 rtl/lrsc_sequencer.sv | 159 +++++++++++++++
 tb/tb_lrsc_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arvi_amo_pkg.sv
// arvi_amo_pkg: shared definitions for the LR.W/SC.W sequencer.
//   lrsc_state_t         - sequencer FSM state encoding
//   SC_SUCCESS / SC_FAIL - SC.W status values written back to rd
//   RESV_TIMEOUT_DEFAULT - default reservation lifetime in cycles
package arvi_amo_pkg;

    typedef enum logic [2:0] {
        LRSC_IDLE    = 3'd0,
        LRSC_LR_WAIT = 3'd1,
        LRSC_SC_WAIT = 3'd2,
        LRSC_RESP    = 3'd3,
        LRSC_ABORT   = 3'd4
    } lrsc_state_t;

    localparam int SC_SUCCESS           = 0;
    localparam int SC_FAIL              = 1;
    localparam int RESV_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/lrsc_reservation.sv
// lrsc_reservation: single-hart LR/SC reservation register.
//   clk, rst    - clock, synchronous active-high reset
//   set/set_tag - establish a reservation on a granule (LR completion)
//   clear       - drop the reservation (SC, misaligned atomic, flush)
//   snoop_vld/snoop_tag - plain store; a granule hit drops the reservation
//   query_tag   - granule of the pending SC
//   match       - reservation valid and on query_tag
//   snoop_hit   - the store this cycle hits the live reservation
module lrsc_reservation
    import arvi_amo_pkg::*;
#(
    parameter int TAG_W        = 30,
    parameter int RESV_TIMEOUT = RESV_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic [TAG_W-1:0] set_tag,
    input  logic             clear,
    input  logic             snoop_vld,
    input  logic [TAG_W-1:0] snoop_tag,
    input  logic [TAG_W-1:0] query_tag,
    output logic             match,
    output logic             snoop_hit
);

    localparam int TW = (RESV_TIMEOUT > 0) ? $clog2(RESV_TIMEOUT + 1) : 1;

    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [TW-1:0]    timer;
    logic             expired;

    // With RESV_TIMEOUT == 0 the timer is never loaded and never expires.
    assign expired   = (RESV_TIMEOUT != 0) && valid && (timer == '0);
    assign snoop_hit = valid && snoop_vld && (snoop_tag == tag);
    assign match     = valid && (query_tag == tag);

    // set has priority so an LR completing alongside a matching store keeps
    // its reservation.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            timer <= '0;
        end else if (set) begin
            valid <= 1'b1;
            tag   <= set_tag;
            timer <= TW'(RESV_TIMEOUT);
        end else if (clear || snoop_hit || expired) begin
            valid <= 1'b0;
            timer <= '0;
        end else if (valid && timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

endmodule

// File: rtl/lrsc_sequencer.sv
// lrsc_sequencer: multi-cycle LR.W / SC.W sequencer beside EX/MEM.
//   i_clk, i_rst          - clock, synchronous active-high reset
//   i_atomic, i_sc        - atomic op in EX (held while o_Stall), SC vs LR
//   i_Addr, i_WData       - effective address, SC store data
//   i_store, i_store_addr - plain store snoop for reservation invalidation
//   i_flush               - trap / pipeline flush
//   o_Stall, o_Done       - pipeline hold, one-cycle result strobe
//   o_Result              - LR data or SC status (0 success, 1 fail)
//   o_misaligned          - strobe with o_Done for a non word-aligned address
//   o_DBus_*, i_DBus_*    - registered request / ack data bus
module lrsc_sequencer
    import arvi_amo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int RESV_GRAN    = 2,
    parameter int RESV_TIMEOUT = RESV_TIMEOUT_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_atomic,
    input  logic                  i_sc,
    input  logic [ADDR_WIDTH-1:0] i_Addr,
    input  logic [DATA_WIDTH-1:0] i_WData,
    input  logic                  i_store,
    input  logic [ADDR_WIDTH-1:0] i_store_addr,
    input  logic                  i_flush,
    output logic                  o_Stall,
    output logic                  o_Done,
    output logic [DATA_WIDTH-1:0] o_Result,
    output logic                  o_misaligned,
    output logic                  o_DBus_req,
    output logic                  o_DBus_we,
    output logic [ADDR_WIDTH-1:0] o_DBus_addr,
    output logic [DATA_WIDTH-1:0] o_DBus_wdata,
    input  logic                  i_DBus_ack,
    input  logic [DATA_WIDTH-1:0] i_DBus_rdata
);

    localparam int TAG_W = ADDR_WIDTH - RESV_GRAN;

    lrsc_state_t      state;
    logic             mis_flag;
    logic             launch;
    logic             misaligned;
    logic             resv_set;
    logic             resv_clear;
    logic             resv_match;
    logic             store_hit;
    logic             sc_ok;
    logic [TAG_W-1:0] addr_tag;
    logic [TAG_W-1:0] store_tag;
    logic [TAG_W-1:0] bus_tag;
    logic             store_lo_unused;

    assign addr_tag        = i_Addr[ADDR_WIDTH-1:RESV_GRAN];
    assign store_tag       = i_store_addr[ADDR_WIDTH-1:RESV_GRAN];
    assign bus_tag         = o_DBus_addr[ADDR_WIDTH-1:RESV_GRAN];
    assign store_lo_unused = ^i_store_addr[RESV_GRAN-1:0];

    // A flush in IDLE kills the instruction before it can start.
    assign launch     = (state == LRSC_IDLE) && i_atomic && !i_flush;
    assign misaligned = (i_Addr[1:0] != 2'b00);

    // A store hitting the reservation in the decision cycle makes the SC fail.
    assign sc_ok      = resv_match && !store_hit;

    assign resv_set   = (state == LRSC_LR_WAIT) && i_DBus_ack && !i_flush;
    // Every SC consumes the reservation at its decision, success or not.
    assign resv_clear = i_flush || (launch && (i_sc || misaligned));

    lrsc_reservation #(
        .TAG_W        (TAG_W),
        .RESV_TIMEOUT (RESV_TIMEOUT)
    ) u_resv (
        .clk       (i_clk),
        .rst       (i_rst),
        .set       (resv_set),
        .set_tag   (bus_tag),
        .clear     (resv_clear),
        .snoop_vld (i_store),
        .snoop_tag (store_tag),
        .query_tag (addr_tag),
        .match     (resv_match),
        .snoop_hit (store_hit)
    );

    assign o_Stall      = ((state == LRSC_IDLE) && i_atomic) ||
                          (state == LRSC_LR_WAIT) ||
                          (state == LRSC_SC_WAIT) ||
                          (state == LRSC_ABORT);
    assign o_Done       = (state == LRSC_RESP) && !i_flush;
    assign o_misaligned = o_Done && mis_flag;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= LRSC_IDLE;
            mis_flag     <= 1'b0;
            o_Result     <= '0;
            o_DBus_req   <= 1'b0;
            o_DBus_we    <= 1'b0;
            o_DBus_addr  <= '0;
            o_DBus_wdata <= '0;
        end else begin
            case (state)
                LRSC_IDLE: begin
                    if (launch) begin
                        if (misaligned) begin
                            state    <= LRSC_RESP;
                            mis_flag <= 1'b1;
                            o_Result <= i_sc ? DATA_WIDTH'(SC_FAIL) : '0;
                        end else if (!i_sc) begin
                            state       <= LRSC_LR_WAIT;
                            o_DBus_req  <= 1'b1;
                            o_DBus_we   <= 1'b0;
                            o_DBus_addr <= i_Addr;
                        end else if (sc_ok) begin
                            state        <= LRSC_SC_WAIT;
                            o_DBus_req   <= 1'b1;
                            o_DBus_we    <= 1'b1;
                            o_DBus_addr  <= i_Addr;
                            o_DBus_wdata <= i_WData;
                        end else begin
                            state    <= LRSC_RESP;
                            o_Result <= DATA_WIDTH'(SC_FAIL);
                        end
                    end
                end
                LRSC_LR_WAIT, LRSC_SC_WAIT: begin
                    if (i_DBus_ack) begin
                        o_DBus_req <= 1'b0;
                        if (i_flush) begin
                            state <= LRSC_IDLE;
                        end else begin
                            state    <= LRSC_RESP;
                            o_Result <= (state == LRSC_LR_WAIT) ? i_DBus_rdata
                                                                : DATA_WIDTH'(SC_SUCCESS);
                        end
                    end else if (i_flush) begin
                        state <= LRSC_ABORT;
                    end
                end
                // The bus transaction cannot be cancelled; wait it out silently.
                LRSC_ABORT: begin
                    if (i_DBus_ack) begin
                        o_DBus_req <= 1'b0;
                        state      <= LRSC_IDLE;
                    end
                end
                LRSC_RESP: begin
                    state    <= LRSC_IDLE;
                    mis_flag <= 1'b0;
                end
                default: state <= LRSC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lrsc_sequencer.sv
// tb_lrsc_sequencer: directed scenarios plus randomized LR/SC traffic checked
// against a reservation model kept as (valid, tag, completion cycle).
module tb_lrsc_sequencer;

    localparam int TO = 4;

    typedef struct {
        int          stall;
        int          done_at;
        int          req;
        int          start_cyc;
        logic [31:0] result;
        logic        mis;
        bit          bus_bad;
        bit          to;
    } obs_t;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_atomic = 1'b0, i_sc = 1'b0, i_store = 1'b0, i_flush = 1'b0;
    logic [31:0] i_Addr = '0, i_WData = '0, i_store_addr = '0;
    logic        i_DBus_ack = 1'b0;
    logic [31:0] i_DBus_rdata = '0;
    logic        o_Stall, o_Done, o_misaligned, o_DBus_req, o_DBus_we;
    logic [31:0] o_Result, o_DBus_addr, o_DBus_wdata;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // reservation model
    bit          m_valid = 0;
    logic [29:0] m_tag = '0;
    int          m_set = 0;

    lrsc_sequencer #(
        .DATA_WIDTH (32), .ADDR_WIDTH (32), .RESV_GRAN (2), .RESV_TIMEOUT (TO)
    ) dut (
        .i_clk (clk), .i_rst (i_rst), .i_atomic (i_atomic), .i_sc (i_sc),
        .i_Addr (i_Addr), .i_WData (i_WData), .i_store (i_store),
        .i_store_addr (i_store_addr), .i_flush (i_flush), .o_Stall (o_Stall),
        .o_Done (o_Done), .o_Result (o_Result), .o_misaligned (o_misaligned),
        .o_DBus_req (o_DBus_req), .o_DBus_we (o_DBus_we),
        .o_DBus_addr (o_DBus_addr), .o_DBus_wdata (o_DBus_wdata),
        .i_DBus_ack (i_DBus_ack), .i_DBus_rdata (i_DBus_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Runs one atomic instruction; the bus acks after 'waits' request cycles.
    task automatic do_atomic(input logic sc, input logic [31:0] addr, wdata, rdata,
                             input int waits, flush_at, st_at,
                             input logic [31:0] st_addr, output obs_t o);
        bit killed = 0;
        bit finished = 0;
        o.stall = 0; o.done_at = -1; o.req = 0; o.start_cyc = 0;
        o.result = '0; o.mis = 0; o.bus_bad = 0; o.to = 0;
        for (int i = 0; i < 40 && !finished; i++) begin
            @(negedge clk);
            i_atomic     = !killed;
            i_sc         = sc;
            i_Addr       = addr;
            i_WData      = wdata;
            i_store      = (i == st_at);
            i_store_addr = st_addr;
            i_flush      = (i == flush_at);
            i_DBus_ack   = o_DBus_req && (o.req == waits);
            i_DBus_rdata = i_DBus_ack ? rdata : $urandom;
            #1;
            if (i == 0) o.start_cyc = cyc;
            if (o_Stall) o.stall++;
            if (o_DBus_req) begin
                o.req++;
                if (o_DBus_we !== sc || o_DBus_addr !== addr || (sc && o_DBus_wdata !== wdata))
                    o.bus_bad = 1;
            end
            if (o_Done && o.done_at < 0) begin
                o.done_at = i; o.result = o_Result; o.mis = o_misaligned;
            end
            if (o.done_at == i) finished = 1;
            if (killed && !o_Stall && !i_flush) finished = 1;
            if (i_flush) killed = 1;
        end
        if (!finished) o.to = 1;
    endtask

    task automatic idle(input int n, st_at, input logic [31:0] st_addr, input int fl_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_atomic = 0; i_DBus_ack = 0;
            i_store = (i == st_at); i_store_addr = st_addr;
            i_flush = (i == fl_at);
        end
    endtask

    task automatic test_reset();
        obs_t o;
        i_rst = 1;
        repeat (3) @(negedge clk);
        #1;
        vectors++; if ({o_Stall, o_Done, o_misaligned} !== 3'b000) begin
            miscompares++; $display("FAIL reset ctl got %b want 000", {o_Stall, o_Done, o_misaligned}); end
        vectors++; if ({o_DBus_req, o_DBus_we, o_DBus_addr, o_DBus_wdata} !== 66'd0) begin
            miscompares++; $display("FAIL reset bus got req=%b addr=%h want 0", o_DBus_req, o_DBus_addr); end
        vectors++; if (o_Result !== 32'd0) begin
            miscompares++; $display("FAIL reset result got %h want 0", o_Result); end
        i_rst = 0;
        // reservation on 0x100, then reset while an LR is on the bus
        do_atomic(0, 32'h100, 0, 32'h1111, 0, -1, -1, 0, o);
        @(negedge clk); i_atomic = 1; i_sc = 0; i_Addr = 32'h104; i_DBus_ack = 0;
        @(negedge clk); #1;
        vectors++; if (o_DBus_req !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid req_before got %b want 1", o_DBus_req); end
        @(negedge clk); i_rst = 1; i_atomic = 0;
        @(negedge clk); #1;
        vectors++; if ({o_DBus_req, o_Stall} !== 2'b00) begin
            miscompares++; $display("FAIL rst_mid req/stall got %b want 00", {o_DBus_req, o_Stall}); end
        i_rst = 0;
        do_atomic(1, 32'h100, 32'h77, 0, 0, -1, -1, 0, o);
        vectors++; if (o.result !== 32'd1 || o.req != 0) begin
            miscompares++; $display("FAIL rst_mid sc got res=%h req=%0d want 1/0", o.result, o.req); end
    endtask

    task automatic test_lr_wait();
        obs_t o;
        do_atomic(0, 32'h100, 0, 32'hDEADBEEF, 2, -1, -1, 0, o);
        vectors++; if (o.stall != 4) begin
            miscompares++; $display("FAIL lr_wait stall got %0d want 4", o.stall); end
        vectors++; if (o.done_at != 4) begin
            miscompares++; $display("FAIL lr_wait done_at got %0d want 4", o.done_at); end
        vectors++; if (o.result !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL lr_wait result got %h want deadbeef", o.result); end
        vectors++; if (o.req != 3 || o.bus_bad) begin
            miscompares++; $display("FAIL lr_wait bus got req=%0d bad=%0d want 3/0", o.req, o.bus_bad); end
        // reservation live on granule 0x40: an SC to 0x100 must go to the bus
        do_atomic(1, 32'h100, 32'h1, 0, 0, -1, -1, 0, o);
        vectors++; if (o.result !== 32'd0 || o.req != 1) begin
            miscompares++; $display("FAIL lr_wait resv got res=%h req=%0d want 0/1", o.result, o.req); end
    endtask

    task automatic test_lr_sc();
        obs_t o;
        do_atomic(0, 32'h100, 0, 32'h12345678, 0, -1, -1, 0, o);
        vectors++; if (o.stall != 2 || o.done_at != 2) begin
            miscompares++; $display("FAIL lr_sc lr_lat got stall=%0d done=%0d want 2/2", o.stall, o.done_at); end
        do_atomic(1, 32'h100, 32'h5A, 0, 0, -1, -1, 0, o);
        vectors++; if (o.req != 1 || o.bus_bad) begin
            miscompares++; $display("FAIL lr_sc write got req=%0d bad=%0d want 1/0", o.req, o.bus_bad); end
        vectors++; if (o.result !== 32'd0) begin
            miscompares++; $display("FAIL lr_sc sc_ok got %h want 0", o.result); end
        do_atomic(1, 32'h100, 32'h5A, 0, 0, -1, -1, 0, o);
        vectors++; if (o.result !== 32'd1 || o.req != 0 || o.done_at != 1 || o.stall != 1) begin
            miscompares++; $display("FAIL lr_sc sc_again got res=%h req=%0d done=%0d stall=%0d want 1/0/1/1",
                                    o.result, o.req, o.done_at, o.stall); end
    endtask

    task automatic test_store_inval();
        obs_t o;
        do_atomic(0, 32'h100, 0, 32'hA, 1, -1, -1, 0, o);
        idle(1, 0, 32'h102, -1);
        do_atomic(1, 32'h100, 32'h9, 0, 0, -1, -1, 0, o);
        vectors++; if (o.result !== 32'd1 || o.req != 0) begin
            miscompares++; $display("FAIL store_hit got res=%h req=%0d want 1/0", o.result, o.req); end
        do_atomic(0, 32'h100, 0, 32'hB, 0, -1, -1, 0, o);
        idle(1, 0, 32'h104, -1);
        do_atomic(1, 32'h100, 32'h9, 0, 0, -1, -1, 0, o);
        vectors++; if (o.result !== 32'd0 || o.req != 1) begin
            miscompares++; $display("FAIL store_other got res=%h req=%0d want 0/1", o.result, o.req); end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_atomic(0, 32'h200, 0, 32'hC, 0, -1, -1, 0, o);
        idle(5, -1, 0, -1);
        do_atomic(1, 32'h200, 32'h3, 0, 0, -1, -1, 0, o);
        vectors++; if (o.result !== 32'd1 || o.req != 0) begin
            miscompares++; $display("FAIL timeout_5 got res=%h req=%0d want 1/0", o.result, o.req); end
        do_atomic(0, 32'h200, 0, 32'hC, 0, -1, -1, 0, o);
        idle(3, -1, 0, -1);
        do_atomic(1, 32'h200, 32'h3, 0, 0, -1, -1, 0, o);
        vectors++; if (o.result !== 32'd0 || o.req != 1) begin
            miscompares++; $display("FAIL timeout_3 got res=%h req=%0d want 0/1", o.result, o.req); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        do_atomic(0, 32'h103, 0, 32'hE, 0, -1, -1, 0, o);
        vectors++; if (o.done_at != 1 || o.mis !== 1'b1 || o.stall != 1) begin
            miscompares++; $display("FAIL mis_lr got done=%0d mis=%b stall=%0d want 1/1/1", o.done_at, o.mis, o.stall); end
        vectors++; if (o.req != 0) begin
            miscompares++; $display("FAIL mis_lr req got %0d want 0", o.req); end
        // a misaligned atomic also drops a live reservation
        do_atomic(0, 32'h100, 0, 32'hF, 0, -1, -1, 0, o);
        do_atomic(1, 32'h101, 32'h2, 0, 0, -1, -1, 0, o);
        vectors++; if (o.mis !== 1'b1 || o.req != 0) begin
            miscompares++; $display("FAIL mis_sc got mis=%b req=%0d want 1/0", o.mis, o.req); end
        do_atomic(1, 32'h100, 32'h2, 0, 0, -1, -1, 0, o);
        vectors++; if (o.result !== 32'd1 || o.mis !== 1'b0) begin
            miscompares++; $display("FAIL mis_clear got res=%h mis=%b want 1/0", o.result, o.mis); end
    endtask

    task automatic test_flush();
        obs_t o;
        do_atomic(0, 32'h100, 0, 32'h5, 0, -1, -1, 0, o);
        do_atomic(0, 32'h100, 0, 32'h6, 2, 1, -1, 0, o);
        vectors++; if (o.done_at != -1 || o.to) begin
            miscompares++; $display("FAIL flush done got %0d to=%0d want -1/0", o.done_at, o.to); end
        vectors++; if (o.req != 3 || o.stall != 4) begin
            miscompares++; $display("FAIL flush hold got req=%0d stall=%0d want 3/4", o.req, o.stall); end
        do_atomic(1, 32'h100, 32'h1, 0, 0, -1, -1, 0, o);
        vectors++; if (o.result !== 32'd1 || o.req != 0) begin
            miscompares++; $display("FAIL flush resv got res=%h req=%0d want 1/0", o.result, o.req); end
    endtask

    task automatic test_simultaneous();
        obs_t o;
        // matching store in the LR ack cycle: the new reservation survives
        do_atomic(0, 32'h300, 0, 32'h8, 1, -1, 2, 32'h300, o);
        do_atomic(1, 32'h300, 32'h4, 0, 0, -1, -1, 0, o);
        vectors++; if (o.result !== 32'd0 || o.req != 1) begin
            miscompares++; $display("FAIL set_wins got res=%h req=%0d want 0/1", o.result, o.req); end
        // matching store in the SC decision cycle: SC fails
        do_atomic(0, 32'h300, 0, 32'h8, 0, -1, -1, 0, o);
        do_atomic(1, 32'h300, 32'h4, 0, 0, -1, 0, 32'h301, o);
        vectors++; if (o.result !== 32'd1 || o.req != 0) begin
            miscompares++; $display("FAIL store_at_sc got res=%h req=%0d want 1/0", o.result, o.req); end
    endtask

    task automatic test_random();
        obs_t        o;
        logic [31:0] bases [4] = '{32'h100, 32'h104, 32'h200, 32'h300};
        idle(1, -1, 0, 0);
        m_valid = 0;
        for (int n = 0; n < 120; n++) begin
            logic        sc, mis, ok, bus, fl;
            logic [31:0] addr, wdata, rdata, st_addr;
            int          w, st_at, fl_at, gap, start, e_done;
            sc    = 1'($urandom_range(0, 1));
            addr  = bases[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
            wdata = $urandom; rdata = $urandom;
            w     = $urandom_range(0, 3);
            st_addr = bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
            st_at = (sc && $urandom_range(0, 3) == 0) ? 0 : -1;
            start = cyc + 1;
            mis   = (addr[1:0] != 2'b00);
            ok    = m_valid && (m_tag == addr[31:2]) && (start - m_set <= TO) &&
                    !(st_at == 0 && st_addr[31:2] == addr[31:2]);
            bus   = !mis && (!sc || ok);
            fl    = bus && ($urandom_range(0, 5) == 0);
            fl_at = fl ? $urandom_range(1, w + 1) : -1;
            e_done = fl ? -1 : (bus ? w + 2 : 1);
            do_atomic(sc, addr, wdata, rdata, w, fl_at, st_at, st_addr, o);
            vectors++; if (o.to) begin
                miscompares++; $display("FAIL rnd%0d no completion within budget", n); end
            vectors++; if (o.done_at != e_done) begin
                miscompares++; $display("FAIL rnd%0d done_at got %0d want %0d", n, o.done_at, e_done); end
            vectors++; if (o.stall != (bus ? w + 2 : 1)) begin
                miscompares++; $display("FAIL rnd%0d stall got %0d want %0d", n, o.stall, bus ? w + 2 : 1); end
            vectors++; if (o.req != (bus ? w + 1 : 0) || o.bus_bad) begin
                miscompares++; $display("FAIL rnd%0d bus got req=%0d bad=%0d want %0d/0", n, o.req, o.bus_bad, bus ? w + 1 : 0); end
            if (e_done > 0) begin
                vectors++; if (o.mis !== mis) begin
                    miscompares++; $display("FAIL rnd%0d mis got %b want %b", n, o.mis, mis); end
                if (!mis) begin
                    logic [31:0] e_res;
                    e_res = sc ? (bus ? 32'd0 : 32'd1) : rdata;
                    vectors++; if (o.result !== e_res) begin
                        miscompares++; $display("FAIL rnd%0d result got %h want %h", n, o.result, e_res); end
                end
            end
            if (!mis && !sc && !fl) begin
                m_valid = 1; m_tag = addr[31:2]; m_set = start + w + 2;
            end else begin
                m_valid = 0;
            end
            gap = $urandom_range(0, 5);
            if (gap > 0) begin
                int s_at, f_at;
                s_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, gap - 1) : -1;
                f_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, gap - 1) : -1;
                st_addr = bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
                idle(gap, s_at, st_addr, f_at);
                if (f_at >= 0) m_valid = 0;
                if (s_at >= 0 && st_addr[31:2] == m_tag) m_valid = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_lr_wait();
        test_lr_sc();
        test_store_inval();
        test_timeout();
        test_misaligned();
        test_flush();
        test_simultaneous();
        test_random();
        idle(2, -1, 0, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
